// File: rtl/cga_alu_smux_q.sv
// ALU S-operand source selector with integrated Q register.
// The selected operand leaves through a registered 2-entry skid buffer (valid/ready).
module cga_alu_smux_q #(
  parameter int unsigned      WIDTH   = 16,
  parameter logic [WIDTH-1:0] Q_RESET = '0
) (
  input  logic             sysclk,
  input  logic             sys_rst_n,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] f_in,
  input  logic             sa,
  input  logic             sb,
  input  logic [1:0]       q_op,
  input  logic             q_sin_msb,
  input  logic             q_sin_lsb,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] s_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q_out,
  output logic             q_sout_lsb,
  output logic             q_sout_msb
);

  localparam logic [1:0] QOP_HOLD = 2'b00;
  localparam logic [1:0] QOP_LOAD = 2'b01;
  localparam logic [1:0] QOP_SHR  = 2'b10;
  localparam logic [1:0] QOP_SHL  = 2'b11;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_main_nxt;
  logic [WIDTH-1:0] w_skid_nxt;
  logic [WIDTH-1:0] w_q_nxt;
  logic [WIDTH-1:0] w_sel;
  logic             w_acc;
  logic             w_pop;

  // Handshake flags decode registered state only; no out_ready -> in_ready path.
  assign in_ready   = (r_state != ST_TWO);
  assign out_valid  = (r_state != ST_EMPTY);
  assign s_out      = r_main;
  assign q_out      = r_q;
  assign q_sout_lsb = r_q[0];
  assign q_sout_msb = r_q[WIDTH-1];

  assign w_acc = in_valid && in_ready;
  assign w_pop = out_valid && out_ready;

  // S source mux; Q is the pre-update register value (read-before-write).
  always_comb begin
    w_sel = '0;
    unique case ({sb, sa})
      2'b00:   w_sel = r_q;
      2'b01:   w_sel = b_in;
      2'b10:   w_sel = '0;
      2'b11:   w_sel = a_in;
      default: w_sel = '0;
    endcase
  end

  // Q register next value; only applied on an accepted request.
  always_comb begin
    w_q_nxt = r_q;
    if (w_acc) begin
      unique case (q_op)
        QOP_HOLD: w_q_nxt = r_q;
        QOP_LOAD: w_q_nxt = f_in;
        QOP_SHR:  w_q_nxt = {q_sin_msb, r_q[WIDTH-1:1]};
        QOP_SHL:  w_q_nxt = {r_q[WIDTH-2:0], q_sin_lsb};
        default:  w_q_nxt = r_q;
      endcase
    end
  end

  // Skid buffer next-state and data steering.
  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    unique case (r_state)
      ST_EMPTY: begin
        if (w_acc) begin
          w_state_nxt = ST_ONE;
          w_main_nxt  = w_sel;
        end
      end
      ST_ONE: begin
        if (w_acc && !w_pop) begin
          w_state_nxt = ST_TWO;
          w_skid_nxt  = w_sel;
        end else if (w_pop && !w_acc) begin
          w_state_nxt = ST_EMPTY;
        end else if (w_acc && w_pop) begin
          w_main_nxt  = w_sel;
        end
      end
      ST_TWO: begin
        if (w_pop) begin
          w_state_nxt = ST_ONE;
          w_main_nxt  = r_skid;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge sysclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= ST_EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
      r_q     <= Q_RESET;
    end else begin
      r_state <= w_state_nxt;
      r_main  <= w_main_nxt;
      r_skid  <= w_skid_nxt;
      r_q     <= w_q_nxt;
    end
  end

endmodule

// File: tb/tb_cga_alu_smux_q.sv
// Directed testbench for cga_alu_smux_q: operand select, Q ops, skid buffer, async reset.
module tb_cga_alu_smux_q;

  localparam int unsigned WIDTH = 16;

  logic             sysclk;
  logic             sys_rst_n;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [WIDTH-1:0] f_in;
  logic             sa;
  logic             sb;
  logic [1:0]       q_op;
  logic             q_sin_msb;
  logic             q_sin_lsb;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] s_out;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] q_out;
  logic             q_sout_lsb;
  logic             q_sout_msb;

  int checks;
  int errors;

  cga_alu_smux_q #(.WIDTH(WIDTH), .Q_RESET(16'h0000)) dut (
    .sysclk     (sysclk),
    .sys_rst_n  (sys_rst_n),
    .a_in       (a_in),
    .b_in       (b_in),
    .f_in       (f_in),
    .sa         (sa),
    .sb         (sb),
    .q_op       (q_op),
    .q_sin_msb  (q_sin_msb),
    .q_sin_lsb  (q_sin_lsb),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .s_out      (s_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .q_out      (q_out),
    .q_sout_lsb (q_sout_lsb),
    .q_sout_msb (q_sout_msb)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic set_sel(input logic [1:0] sel);
    {sb, sa} = sel;
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;
    a_in = '0; b_in = '0; f_in = '0; sa = 1'b0; sb = 1'b0;
    q_op = 2'b00; q_sin_msb = 1'b0; q_sin_lsb = 1'b0;
    #23;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (s_out !== 16'h0000) begin errors++; $display("FAIL reset_s_out got=%h exp=0000", s_out); end
    checks++; if (q_out !== 16'h0000) begin errors++; $display("FAIL reset_q got=%h exp=0000", q_out); end
    @(negedge sysclk);
    sys_rst_n = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_select();
    out_ready = 1'b1;
    in_valid = 1'b1; set_sel(2'b10); q_op = 2'b01; f_in = 16'h5A5A;
    tick();
    checks++; if (q_out !== 16'h5A5A) begin errors++; $display("FAIL sel_qload got=%h exp=5a5a", q_out); end
    a_in = 16'h1234; b_in = 16'hABCD; q_op = 2'b00;
    set_sel(2'b00); tick();
    checks++; if (s_out !== 16'h5A5A || out_valid !== 1'b1) begin errors++; $display("FAIL sel_q got=%h/%b exp=5a5a/1", s_out, out_valid); end
    set_sel(2'b01); tick();
    checks++; if (s_out !== 16'hABCD || out_valid !== 1'b1) begin errors++; $display("FAIL sel_b got=%h/%b exp=abcd/1", s_out, out_valid); end
    set_sel(2'b10); tick();
    checks++; if (s_out !== 16'h0000 || out_valid !== 1'b1) begin errors++; $display("FAIL sel_zero got=%h/%b exp=0000/1", s_out, out_valid); end
    set_sel(2'b11); tick();
    checks++; if (s_out !== 16'h1234 || out_valid !== 1'b1) begin errors++; $display("FAIL sel_a got=%h/%b exp=1234/1", s_out, out_valid); end
    in_valid = 1'b0; tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sel_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_qops();
    out_ready = 1'b1;
    in_valid = 1'b1; set_sel(2'b10); q_op = 2'b01; f_in = 16'h8001;
    tick();
    checks++; if (q_out !== 16'h8001) begin errors++; $display("FAIL q_load got=%h exp=8001", q_out); end
    checks++; if (q_sout_lsb !== 1'b1 || q_sout_msb !== 1'b1) begin errors++; $display("FAIL q_sout_pre got=%b%b exp=11", q_sout_msb, q_sout_lsb); end
    q_op = 2'b10; q_sin_msb = 1'b0; tick();
    checks++; if (q_out !== 16'h4000) begin errors++; $display("FAIL q_shr got=%h exp=4000", q_out); end
    checks++; if (q_sout_lsb !== 1'b0 || q_sout_msb !== 1'b0) begin errors++; $display("FAIL q_sout_shr got=%b%b exp=00", q_sout_msb, q_sout_lsb); end
    q_op = 2'b11; q_sin_lsb = 1'b1; tick();
    checks++; if (q_out !== 16'h8001) begin errors++; $display("FAIL q_shl got=%h exp=8001", q_out); end
    q_op = 2'b00; tick();
    checks++; if (q_out !== 16'h8001) begin errors++; $display("FAIL q_hold got=%h exp=8001", q_out); end
    in_valid = 1'b0; q_op = 2'b01; f_in = 16'hFFFF; tick();
    checks++; if (q_out !== 16'h8001) begin errors++; $display("FAIL q_noacc got=%h exp=8001", q_out); end
    in_valid = 1'b1; q_op = 2'b10; q_sin_msb = 1'b1; tick();
    checks++; if (q_out !== 16'hC000) begin errors++; $display("FAIL q_shr_sin1 got=%h exp=c000", q_out); end
    q_op = 2'b11; q_sin_lsb = 1'b0; tick();
    checks++; if (q_out !== 16'h8000 || q_sout_msb !== 1'b1) begin errors++; $display("FAIL q_shl_sin0 got=%h/%b exp=8000/1", q_out, q_sout_msb); end
    in_valid = 1'b0; q_op = 2'b00; tick();
  endtask

  task automatic test_read_before_write();
    out_ready = 1'b1;
    in_valid = 1'b1; set_sel(2'b10); q_op = 2'b01; f_in = 16'h00FF;
    tick();
    set_sel(2'b00); q_op = 2'b01; f_in = 16'h1111;
    tick();
    checks++; if (s_out !== 16'h00FF) begin errors++; $display("FAIL rbw_s_out got=%h exp=00ff", s_out); end
    checks++; if (q_out !== 16'h1111) begin errors++; $display("FAIL rbw_q got=%h exp=1111", q_out); end
    in_valid = 1'b0; q_op = 2'b00; tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rbw_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; set_sel(2'b01); q_op = 2'b00;
    b_in = 16'd1; tick();
    checks++; if (in_ready !== 1'b1 || s_out !== 16'd1) begin errors++; $display("FAIL bp_first got=%b/%h exp=1/0001", in_ready, s_out); end
    b_in = 16'd2; tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full got=%b exp=0", in_ready); end
    b_in = 16'd3; tick();
    checks++; if (in_ready !== 1'b0 || s_out !== 16'd1 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_stall got=%b/%h/%b exp=0/0001/1", in_ready, s_out, out_valid); end
    out_ready = 1'b1; tick();
    checks++; if (s_out !== 16'd2 || out_valid !== 1'b1 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_second got=%h/%b/%b exp=0002/1/1", s_out, out_valid, in_ready); end
    tick();
    checks++; if (s_out !== 16'd3 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_third got=%h/%b exp=0003/1", s_out, out_valid); end
    in_valid = 1'b0; tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] exp_v;
    out_ready = 1'b1;
    in_valid = 1'b1; set_sel(2'b11); q_op = 2'b00;
    for (int i = 0; i < 6; i++) begin
      a_in = 16'h0100 + WIDTH'(i);
      exp_v = a_in;
      tick();
      checks++;
      if (s_out !== exp_v || out_valid !== 1'b1 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_%0d got=%h/%b/%b exp=%h/1/1", i, s_out, out_valid, in_ready, exp_v);
      end
    end
    in_valid = 1'b0; tick();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b1;
    in_valid = 1'b1; set_sel(2'b10); q_op = 2'b01; f_in = 16'hBEEF;
    tick();
    out_ready = 1'b0; set_sel(2'b01); q_op = 2'b00; b_in = 16'h0077;
    tick();
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || q_out !== 16'hBEEF) begin errors++; $display("FAIL ar_pre got=%b/%b/%h exp=0/1/beef", in_ready, out_valid, q_out); end
    in_valid = 1'b0;
    #3 sys_rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || s_out !== 16'h0000 || q_out !== 16'h0000) begin errors++; $display("FAIL ar_assert got=%b/%h/%h exp=0/0000/0000", out_valid, s_out, q_out); end
    @(negedge sysclk);
    sys_rst_n = 1'b1;
    out_ready = 1'b1; in_valid = 1'b1; set_sel(2'b11); a_in = 16'h0ACE;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ar_in_ready got=%b exp=1", in_ready); end
    tick();
    checks++; if (s_out !== 16'h0ACE || out_valid !== 1'b1) begin errors++; $display("FAIL ar_first got=%h/%b exp=0ace/1", s_out, out_valid); end
    in_valid = 1'b0; tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ar_drain got=%b exp=0", out_valid); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_select();
    test_qops();
    test_read_before_write();
    test_backpressure();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cga_alu_smux_q.md
Name: cga_alu_smux_q

Overview:
- Next-generation ALU S-operand source selector with an integrated Q register.
- Selects the S operand from A, B, Q or zero.
- The Q register can hold, load from the ALU result, or shift left/right with serial in/out.
- The selected operand passes through a registered 2-entry skid buffer with a valid/ready handshake, so the ALU front end can stall without losing operands.

Parameters:
- WIDTH, 16, data width of A, B, F, Q and S.
- Q_RESET, 0, reset value of the Q register (WIDTH bits).

Ports:
- sysclk  in  1  single system clock, rising edge.
- sys_rst_n  in  1  asynchronous active-low reset.
- a_in  in  WIDTH  A operand.
- b_in  in  WIDTH  B operand.
- f_in  in  WIDTH  ALU result, used for Q load.
- sa  in  1  source select, low bit.
- sb  in  1  source select, high bit.
- q_op  in  2  Q operation: 00 hold, 01 load f_in, 10 shift right, 11 shift left.
- q_sin_msb  in  1  bit shifted into Q[WIDTH-1] on shift right.
- q_sin_lsb  in  1  bit shifted into Q[0] on shift left.
- in_valid  in  1  request carries a valid select/q_op.
- in_ready  out  1  block can accept a request.
- s_out  out  WIDTH  selected S operand (registered).
- out_valid  out  1  s_out holds a valid operand.
- out_ready  in  1  consumer accepts s_out.
- q_out  out  WIDTH  current Q register.
- q_sout_lsb  out  1  Q[0], shift-out on right shift.
- q_sout_msb  out  1  Q[WIDTH-1], shift-out on left shift.

Behaviour:
- Select encoding {sb,sa}:
  - 00 = Q (current register value)
  - 01 = B
  - 10 = zero
  - 11 = A
- Accept occurs when in_valid && in_ready at the rising edge of sysclk.
- On accept:
  - The selected operand is pushed into the buffer.
  - q_op is applied to Q in the same edge.
  - A Q-selected operand captures the Q value before that edge's update (read-before-write).
- On a non-accepted cycle, Q holds regardless of q_op.
- Q update rules:
  - Shift right: Q <= {q_sin_msb, Q[WIDTH-1:1]}.
  - Shift left: Q <= {Q[WIDTH-2:0], q_sin_lsb}.
  - Load: Q <= f_in.
- q_out, q_sout_lsb and q_sout_msb reflect the registered Q combinationally.
- Buffer:
  - Two entries: a main register driving s_out and a skid register.
  - Latency is 1 cycle: an operand accepted at edge N is on s_out with out_valid=1 after edge N if main was empty or is being drained.
  - in_ready = !skid_full, so it depends only on registered state (no combinational path from out_ready).
- Buffer states:
  - EMPTY (0 entries)
  - ONE (main full)
  - TWO (main and skid full)
- Transitions (acc = accept, pop = out_valid && out_ready):
  - EMPTY, acc -> ONE.
  - ONE, acc && !pop -> TWO (data into skid).
  - ONE, pop && !acc -> EMPTY.
  - ONE, acc && pop -> ONE (main <= new data).
  - TWO, pop -> ONE (main <= skid). acc is impossible in TWO because in_ready=0.
  - Otherwise hold.
- Ordering is strictly FIFO: no reordering, no drop, no duplicate.
- s_out holds its value while out_valid && !out_ready.
- s_out is don't-care when out_valid=0; it is driven to 0 after reset.
- Reset (sys_rst_n low, asynchronous, any time, including mid-stall):
  - state EMPTY, out_valid=0, s_out=0, skid cleared, Q=Q_RESET.
  - in_ready rises in the first cycle after reset deasserts.
  - Entries in flight are discarded.
- WIDTH ≥ 2 is required. There is no arithmetic and no width extension: all paths are exactly WIDTH bits.

Test Plan:
- Select sweep, WIDTH=16, out_ready=1, A=0x1234, B=0xABCD, Q=0x5A5A. Send {sb,sa}=00,01,10,11 back-to-back. Required: s_out = 0x5A5A, 0xABCD, 0x0000, 0x1234 on consecutive cycles, each 1 cycle after accept.
- Q ops:
  - Load f_in=0x8001.
  - Shift right with q_sin_msb=0 -> Q=0x4000, q_sout_lsb was 1 before the edge.
  - Shift left with q_sin_lsb=1 -> Q=0x8001.
  - Hold -> unchanged.
  - in_valid=0 with q_op=01 -> Q unchanged.
- Read-before-write: Q=0x00FF, request {sb,sa}=00 with q_op=01, f_in=0x1111. Required: s_out=0x00FF and Q=0x1111 after the edge.
- Backpressure: out_ready=0, send 3 requests (B=1,2,3). Required: in_ready drops after the 2nd accept and the 3rd is held off. Raising out_ready yields 1,2,3 in order with no gaps once streaming.
- Simultaneous push/pop in ONE state, each cycle with out_ready=1. Required: continuous throughput of 1 operand/cycle, in_ready stays 1.
- Async reset while in TWO with Q=0xBEEF. Required: immediately out_valid=0, s_out=0, Q=Q_RESET; after release, first new request appears with latency 1.
